// File: rtl/md_unit_if.sv
// md_unit_if: command/result bundle between the E stage and the multiply/divide unit.
// The E stage (master) drives the commands and operands. The unit (slave) returns busy and HI/LO.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic        mt_hi;
  logic        mt_lo;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, mt_hi, mt_lo, src_a, src_b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, mt_hi, mt_lo, src_a, src_b,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: MIPS multiply/divide unit holding the architectural HI/LO registers.
//
// The 64-bit result is computed in full at the start edge and parked in a pending
// register. A down-counter then models the fixed latency, and {hi,lo} takes the
// pending value on the edge where the counter runs out. While the counter runs,
// busy is high and HI/LO are frozen.
//
// Optional build macro MD_MADD_EN enables MADD/MADDU (md_op 4/5). These accumulate
// the product into {hi,lo}. Without the macro, md_op 4/5 are reserved and ignored.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  md_unit_if.slave bus
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pend_q;
  logic        pend_wr_q;
  logic        pend_acc_q;
  logic [31:0] hi_q, lo_q;

  logic        op_mul, op_div, op_acc, op_sgn;
  logic        accept, done;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] mag_a, mag_b, div_b, uq, ur, quo, rem;
  logic [63:0] result;

  // Decode md_op into unit class and signedness.
  always_comb begin
    op_mul = 1'b0;
    op_div = 1'b0;
    op_acc = 1'b0;
    op_sgn = 1'b0;
    case (bus.md_op)
      3'd0: begin op_mul = 1'b1; op_sgn = 1'b1; end
      3'd1: op_mul = 1'b1;
      3'd2: begin op_div = 1'b1; op_sgn = 1'b1; end
      3'd3: op_div = 1'b1;
`ifdef MD_MADD_EN
      3'd4: begin op_mul = 1'b1; op_acc = 1'b1; op_sgn = 1'b1; end
      3'd5: begin op_mul = 1'b1; op_acc = 1'b1; end
`else
`endif
      default: ;
    endcase
  end

  assign accept = bus.start && (state_q == S_IDLE) && (op_mul || op_div);
  assign done   = (state_q == S_RUN) && (cnt_q == 4'd1);

  // Full-width result, computed from the operands present at the start edge.
  // Division works on magnitudes and fixes the signs afterwards. Because of this,
  // 0x80000000 / -1 naturally yields quotient 0x80000000 and remainder 0.
  // A zero divisor is replaced by 1 only to keep the divider defined. That result
  // is never written back.
  always_comb begin
    ext_a  = op_sgn ? {{32{bus.src_a[31]}}, bus.src_a} : {32'd0, bus.src_a};
    ext_b  = op_sgn ? {{32{bus.src_b[31]}}, bus.src_b} : {32'd0, bus.src_b};
    prod   = ext_a * ext_b;
    mag_a  = (op_sgn && bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;
    mag_b  = (op_sgn && bus.src_b[31]) ? (32'd0 - bus.src_b) : bus.src_b;
    div_b  = (mag_b == 32'd0) ? 32'd1 : mag_b;
    uq     = mag_a / div_b;
    ur     = mag_a % div_b;
    quo    = (op_sgn && (bus.src_a[31] ^ bus.src_b[31])) ? (32'd0 - uq) : uq;
    rem    = (op_sgn && bus.src_a[31]) ? (32'd0 - ur) : ur;
    result = op_div ? {rem, quo} : prod;
  end

  // State register and latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load the latency on accept, then count down to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        cnt_d   = op_div ? DIV_N : MULT_N;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Capture the pending result and how to retire it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= 64'd0;
      pend_wr_q  <= 1'b0;
      pend_acc_q <= 1'b0;
    end else if (accept) begin
      pend_q     <= result;
      pend_wr_q  <= !(op_div && (bus.src_b == 32'd0));
      pend_acc_q <= op_acc;
    end
  end

  // HI/LO: written back on completion, or by mthi/mtlo when fully idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (done) begin
      if (pend_wr_q) {hi_q, lo_q} <= pend_acc_q ? ({hi_q, lo_q} + pend_q) : pend_q;
    end else if ((state_q == S_IDLE) && !bus.start) begin
      if (bus.mt_hi) hi_q <= bus.src_a;
      if (bus.mt_lo) lo_q <= bus.src_a;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit.
// The stimulus pushes the expected completions and idle snapshots. A negedge
// monitor measures each busy period and compares the results it sees.
module tb_md_unit;

  typedef struct {
    string       name;
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } op_exp_t;

  typedef struct {
    string       name;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } snap_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  op_exp_t op_q[$];
  snap_t   snap_q[$];
  int      checks = 0;
  int      failures = 0;
  int      timeouts = 0;
  int      rst_evt = 0;
  bit      done = 1'b0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic expect_op(input string n, input int cyc, input logic [31:0] h, input logic [31:0] l);
    op_exp_t e;
    e.name = n; e.cycles = cyc; e.hi = h; e.lo = l;
    op_q.push_back(e);
  endtask

  task automatic snap(input string n, input logic b, input logic [31:0] h, input logic [31:0] l);
    snap_t s;
    s.name = n; s.busy = b; s.hi = h; s.lo = l;
    snap_q.push_back(s);
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.md_op = op; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.src_a = ~a; bus.src_b = ~b;
  endtask

  task automatic mt(input logic h, input logic l, input logic [31:0] a);
    @(posedge clk); #1;
    bus.mt_hi = h; bus.mt_lo = l; bus.src_a = a;
    @(posedge clk); #1;
    bus.mt_hi = 1'b0; bus.mt_lo = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    timeouts++;
  endtask

  // Count reset pulses so the monitor can drop a busy period that reset aborted.
  initial forever begin
    @(posedge reset);
    rst_evt++;
  end

  // Monitor: time each busy period and check its writeback. Also service the snapshots.
  initial begin
    int      run_cnt;
    int      rst_seen;
    op_exp_t e;
    snap_t   s;
    run_cnt = 0;
    rst_seen = 0;
    forever begin
      @(negedge clk);
      if (rst_evt != rst_seen) begin
        rst_seen = rst_evt;
        run_cnt = 0;
      end
      if (bus.busy) run_cnt++;
      else if (run_cnt != 0) begin
        if (op_q.size() == 0) chk("unexpected_completion", 64'(run_cnt), 64'd0);
        else begin
          e = op_q.pop_front();
          chk({e.name, "_busy_cycles"}, 64'(run_cnt), 64'(e.cycles));
          chk({e.name, "_hi"}, {32'd0, bus.hi}, {32'd0, e.hi});
          chk({e.name, "_lo"}, {32'd0, bus.lo}, {32'd0, e.lo});
        end
        run_cnt = 0;
      end
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        chk({s.name, "_busy"}, {63'd0, bus.busy}, {63'd0, s.busy});
        chk({s.name, "_hi"}, {32'd0, bus.hi}, {32'd0, s.hi});
        chk({s.name, "_lo"}, {32'd0, bus.lo}, {32'd0, s.lo});
      end
      if (done) begin
        chk("ops_left", 64'(op_q.size()), 64'd0);
        chk("timeouts", 64'(timeouts), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    bus.start = 1'b0; bus.md_op = 3'd0; bus.mt_hi = 1'b0; bus.mt_lo = 1'b0;
    bus.src_a = 32'd0; bus.src_b = 32'd0;
    #12 snap("reset", 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    expect_op("mult_neg", 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    launch(3'd0, 32'hFFFFFFFD, 32'd5); wait_idle();

    expect_op("divu", 10, 32'd2, 32'd14);
    launch(3'd3, 32'd100, 32'd7); wait_idle();

    expect_op("div_neg", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    launch(3'd2, 32'hFFFFFFF9, 32'd2); wait_idle();

    expect_op("div_ovf", 10, 32'd0, 32'h80000000);
    launch(3'd2, 32'h80000000, 32'hFFFFFFFF); wait_idle();

    mt(1'b1, 1'b1, 32'h55);
    snap("mt_both", 1'b0, 32'h55, 32'h55);
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    snap("mt_pre_div0", 1'b0, 32'h11, 32'h22);

    expect_op("divu_zero", 10, 32'h11, 32'h22);
    launch(3'd3, 32'h1234, 32'd0); wait_idle();

    // MULTU with a DIV start and an mthi arriving in busy cycle 2; both must be dropped
    expect_op("multu_conflict", 5, 32'hFFFFFFFE, 32'h00000001);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.md_op = 3'd1; bus.src_a = 32'hFFFFFFFF; bus.src_b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.src_a = 32'd0; bus.src_b = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.md_op = 3'd2; bus.src_a = 32'hAAAA5555; bus.src_b = 32'd3; bus.mt_hi = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mt_hi = 1'b0;
    wait_idle();

    mt(1'b1, 1'b0, 32'hDEADBEEF);
    snap("mthi", 1'b0, 32'hDEADBEEF, 32'h00000001);
    mt(1'b0, 1'b1, 32'h12345678);
    snap("mtlo", 1'b0, 32'hDEADBEEF, 32'h12345678);

    // start outranks mtlo issued in the same cycle; HI/LO are held while running
    expect_op("mult_prio", 5, 32'd0, 32'd6);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.md_op = 3'd0; bus.src_a = 32'd2; bus.src_b = 32'd3; bus.mt_lo = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mt_lo = 1'b0;
    snap("hold_in_run", 1'b1, 32'hDEADBEEF, 32'h12345678);
    wait_idle();

    // async reset in busy cycle 3 aborts the MULT with no later writeback
    launch(3'd0, 32'd7, 32'd7);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    snap("async_reset", 1'b0, 32'd0, 32'd0);
    repeat (12) @(posedge clk);
    #1 snap("no_writeback", 1'b0, 32'd0, 32'd0);

    mt(1'b0, 1'b1, 32'hFFFFFFFF);
`ifdef MD_MADD_EN
    expect_op("maddu", 5, 32'd1, 32'd0);
    launch(3'd5, 32'd1, 32'd1); wait_idle();
    mt(1'b0, 1'b1, 32'hFFFFFFFF);
    mt(1'b1, 1'b0, 32'h0);
`else
    launch(3'd4, 32'd3, 32'd3);
    snap("reserved4", 1'b0, 32'd0, 32'hFFFFFFFF);
`endif
    launch(3'd7, 32'd3, 32'd3);
    snap("reserved7", 1'b0, 32'd0, 32'hFFFFFFFF);

    repeat (2) @(posedge clk);
    done = 1'b1;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the E stage of the 5-stage MIPS pipeline. It consumes forwarded rs/rt operands and produces HI/LO for mfhi/mflo.
- Models fixed multi-cycle latency with a busy flag. The hazard unit uses this flag to stall D-stage md/mf/mt instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu); legal range 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  launch operation in md_op; sampled at rising clk
- md_op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MADD 5=MADDU (4/5 only with MD_MADD_EN); 6/7 reserved
- mt_hi  input  1  write src_a to HI (mthi)
- mt_lo  input  1  write src_a to LO (mtlo)
- src_a  input  32  rs operand (forwarded E-stage value)
- src_b  input  32  rt operand (forwarded E-stage value)
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (async, any time, including mid-operation):
  - hi=0, lo=0, busy=0, internal counter=0.
  - Pending result discarded.
- State: IDLE (cnt==0) / RUN (cnt!=0); busy = (cnt!=0), a registered output.
- Start accepted (rising edge with start=1, busy=0, md_op legal):
  - cnt loads MULT_CYCLES or DIV_CYCLES.
  - The 64-bit result is computed from src_a/src_b at that edge and held in a pending register.
  - Operands need not stay stable afterwards.
- RUN:
  - cnt decrements each edge.
  - On the edge where cnt goes 1->0, {hi,lo} <= pending and busy falls.
  - So busy is high for exactly N cycles after the start edge. New HI/LO is visible in the first cycle busy=0.
- HI/LO hold their old values throughout RUN.
- MULT: signed 32x32->64, hi=upper, lo=lower. MULTU: same, unsigned.
- DIV/DIVU: lo=quotient, hi=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (src_b==0):
  - Full DIV_CYCLES busy period.
  - hi/lo left unchanged at completion.
- mt_hi/mt_lo:
  - Accepted only when busy=0 and start=0; writes src_a at the edge, visible next cycle.
  - mt_hi and mt_lo may both be asserted at once; both registers are written.
- Conflicts, all ignored with no state change:
  - start while busy=1.
  - mt_* while busy=1.
  - mt_* in the same cycle as an accepted start (start has priority).
  - Reserved md_op.
- No combinational path from inputs to any output.

Optional Feature:
- Macro MD_MADD_EN.
- Defined:
  - md_op 4 (MADD) gives {hi,lo} <= {hi,lo} + signed(src_a)*signed(src_b), modulo 2^64.
  - md_op 5 (MADDU) does the same unsigned.
  - Latency is MULT_CYCLES.
  - The accumulate uses the {hi,lo} value at the completion edge. This equals the value at the start edge, since HI/LO cannot change during RUN.
- Undefined: md_op 4/5 are reserved and ignored like 6/7.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5 -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU 100/7 -> busy 10 cycles, then lo=14, hi=2. DIV 0xFFFFFFF9 (-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU x/0 with hi=0x11, lo=0x22 beforehand -> busy 10 cycles, then hi=0x11, lo=0x22.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, second start (DIV) and mt_hi asserted on cycle 2 of busy -> both ignored; hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- mthi 0xDEADBEEF and mtlo 0x12345678 while idle -> hi/lo update next cycle. Then MULT started, and reset pulsed asynchronously mid-cycle at cycle 3 -> hi=lo=0 and busy=0 immediately; no later writeback.
- With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU 1*1 -> hi=1, lo=0 after 5 cycles. Without the macro, md_op=4 -> busy stays 0, hi/lo unchanged.
